// File: rtl/frame_filler.sv
// Fills the whole DDR2 frame buffer with one colour, pushing one address and
// two write-data words per 8-pixel burst into the memory arbiter FIFOs.
module frame_filler #(
    parameter int unsigned H_PIXELS = 1024,
    parameter int unsigned V_PIXELS = 768,
    parameter logic [31:0] FB_BASE  = 32'h1080_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [23:0]  filler_color,
    input  logic         filler_valid,
    output logic         filler_ready,
    output logic [30:0]  af_addr_din,
    output logic         af_wr_en,
    input  logic         af_full,
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din,
    output logic         wdf_wr_en,
    input  logic         wdf_full,
    output logic         fill_done
);

    localparam int unsigned NBURST = H_PIXELS * V_PIXELS / 8;
    localparam int unsigned CNT_W  = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(NBURST - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      colour_q, colour_d;
    logic             fill_done_q, fill_done_d;
    logic             cmd_push;
    logic             data_push;

    // The low 31 bits of the 32-bit sum equal the 31-bit sum, so only those are formed.
    assign af_addr_din  = FB_BASE[30:0] + (31'(cnt_q) << 5);
    assign wdf_din      = {4{8'h00, colour_q}};
    assign wdf_mask_din = 16'h0000;
    assign fill_done    = fill_done_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        colour_d     = colour_q;
        fill_done_d  = 1'b0;
        filler_ready = 1'b0;
        cmd_push     = 1'b0;
        data_push    = 1'b0;
        af_wr_en     = 1'b0;
        wdf_wr_en    = 1'b0;

        // Reset gates every output so no enable fires in the reset cycle.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    filler_ready = 1'b1;
                    if (filler_valid) begin
                        colour_d = filler_color;
                        cnt_d    = '0;
                        state_d  = StCmd;
                    end
                end
                StCmd: begin
                    // Address and first data word go together or not at all.
                    cmd_push  = ~af_full & ~wdf_full;
                    af_wr_en  = cmd_push;
                    wdf_wr_en = cmd_push;
                    if (cmd_push) begin
                        state_d = StData2;
                    end
                end
                StData2: begin
                    data_push = ~wdf_full;
                    wdf_wr_en = data_push;
                    if (data_push) begin
                        if (cnt_q == LAST_BURST) begin
                            state_d     = StIdle;
                            fill_done_d = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = StCmd;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            colour_q    <= 24'h000000;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            colour_q    <= colour_d;
            fill_done_q <= fill_done_d;
        end
    end

endmodule

// File: tb/tb_frame_filler.sv
// Directed bench for frame_filler on a 16x2 frame (4 bursts), with a queue
// scoreboard of expected addresses, data words and fill_done cycles.
module tb_frame_filler;

    localparam int unsigned HP   = 16;
    localparam int unsigned VP   = 2;
    localparam logic [31:0] BASE = 32'h1080_0000;
    localparam int          NB   = HP * VP / 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [23:0]  filler_color = 24'h000000;
    logic         filler_valid = 1'b0;
    logic         af_full = 1'b0;
    logic         wdf_full = 1'b0;
    logic         filler_ready;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_wr_en;
    logic         fill_done;

    frame_filler #(
        .H_PIXELS (HP),
        .V_PIXELS (VP),
        .FB_BASE  (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .filler_color (filler_color),
        .filler_valid (filler_valid),
        .filler_ready (filler_ready),
        .af_addr_din  (af_addr_din),
        .af_wr_en     (af_wr_en),
        .af_full      (af_full),
        .wdf_din      (wdf_din),
        .wdf_mask_din (wdf_mask_din),
        .wdf_wr_en    (wdf_wr_en),
        .wdf_full     (wdf_full),
        .fill_done    (fill_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [30:0]  exp_af[$];
    logic [127:0] exp_wdf[$];
    int           exp_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_vec(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_fill(logic [23:0] c, int done_cyc);
        for (int k = 0; k < NB; k++) begin
            logic [31:0] a;
            a = BASE + 32'(k) * 32'd32;
            exp_af.push_back(a[30:0]);
            exp_wdf.push_back({4{8'h00, c}});
            exp_wdf.push_back({4{8'h00, c}});
        end
        exp_done.push_back(done_cyc);
    endtask

    // Called just after a rising edge with the block idle; the next edge accepts.
    task automatic start_fill(logic [23:0] c, int lat, bit hold);
        check_bit("ready_before_accept", filler_ready, 1'b1);
        filler_color = c;
        filler_valid = 1'b1;
        push_fill(c, cyc + 1 + lat);
        step(1);
        if (!hold) filler_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_done.size() != 0 && n < 100) begin
            step(1);
            n++;
        end
        check_int("fill_done_seen", exp_done.size(), 0);
        check_int("af_queue_drained", exp_af.size(), 0);
        check_int("wdf_queue_drained", exp_wdf.size(), 0);
    endtask

    always @(negedge clk) begin
        if (af_wr_en === 1'b1) begin
            check_bit("af_with_first_wdf", wdf_wr_en, 1'b1);
            check_bit("af_push_expected", exp_af.size() != 0, 1'b1);
            if (exp_af.size() != 0) begin
                check_vec("af_addr", 128'(af_addr_din), 128'(exp_af.pop_front()));
            end
        end
        if (wdf_wr_en === 1'b1) begin
            check_bit("wdf_push_expected", exp_wdf.size() != 0, 1'b1);
            if (exp_wdf.size() != 0) begin
                check_vec("wdf_data", wdf_din, exp_wdf.pop_front());
            end
            check_vec("wdf_mask", 128'(wdf_mask_din), 128'(0));
        end
        if (fill_done === 1'b1) begin
            check_bit("fill_done_expected", exp_done.size() != 0, 1'b1);
            if (exp_done.size() != 0) begin
                check_int("fill_done_cycle", cyc, exp_done.pop_front());
            end
            check_bit("ready_at_done", filler_ready, 1'b1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        check_bit("rst_ready", filler_ready, 1'b0);
        check_bit("rst_af_en", af_wr_en, 1'b0);
        check_bit("rst_wdf_en", wdf_wr_en, 1'b0);
        check_bit("rst_fill_done", fill_done, 1'b0);
        step(2);
        rst = 1'b0;
        #1;
        check_bit("ready_after_rst", filler_ready, 1'b1);
        check_bit("done_after_rst", fill_done, 1'b0);
        step(1);

        // Basic fill, no backpressure
        start_fill(24'hFF8000, 8, 1'b0);
        wait_done();

        // af_full for 5 cycles in the command phase of burst 1
        start_fill(24'hFF8000, 13, 1'b0);
        step(2);
        af_full = 1'b1;
        #1;
        check_bit("af_stall_af_en", af_wr_en, 1'b0);
        check_bit("af_stall_wdf_en", wdf_wr_en, 1'b0);
        step(5);
        af_full = 1'b0;
        wait_done();

        // wdf_full for 3 cycles on the second word of burst 2
        start_fill(24'hFF8000, 11, 1'b0);
        step(5);
        wdf_full = 1'b1;
        #1;
        check_bit("wdf_stall_wdf_en", wdf_wr_en, 1'b0);
        step(3);
        wdf_full = 1'b0;
        wait_done();

        // Request while busy is ignored
        start_fill(24'hFF8000, 8, 1'b0);
        step(2);
        filler_color = 24'h00FF00;
        filler_valid = 1'b1;
        #1;
        check_bit("busy_ready_low", filler_ready, 1'b0);
        step(3);
        filler_valid = 1'b0;
        wait_done();

        // Reset after two bursts abandons the fill
        start_fill(24'hFF8000, 8, 1'b0);
        step(4);
        check_int("bursts_before_rst", exp_af.size(), NB - 2);
        rst = 1'b1;
        #1;
        check_bit("midrst_af_en", af_wr_en, 1'b0);
        check_bit("midrst_wdf_en", wdf_wr_en, 1'b0);
        check_bit("midrst_ready", filler_ready, 1'b0);
        step(1);
        rst = 1'b0;
        exp_af.delete();
        exp_wdf.delete();
        exp_done.delete();
        #1;
        check_bit("ready_after_midrst", filler_ready, 1'b1);
        check_bit("no_done_after_midrst", fill_done, 1'b0);
        step(10);
        start_fill(24'h0000FF, 8, 1'b0);
        wait_done();

        // Back-to-back fills with filler_valid held high
        start_fill(24'hFF8000, 8, 1'b1);
        filler_color = 24'h123456;
        push_fill(24'h123456, cyc + 9 + 8);
        step(9);
        filler_valid = 1'b0;
        #1;
        check_bit("second_fill_busy", filler_ready, 1'b0);
        wait_done();

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_filler.md
Name: frame_filler

Overview:
- Responder end of the CPU's filler_color/filler_valid/filler_ready command interface.
- On an accepted command, the block writes one 24-bit colour to every pixel of the frame buffer in DDR2.
- It writes through the MIG-style address FIFO (af) and write-data FIFO (wdf) ports of the memory arbiter.
- It sits between Riscv150 and Memory150 on cpu_clk_g and releases the CPU handshake when the fill completes.

Parameters:
- H_PIXELS, 1024, pixels per frame-buffer row.
- V_PIXELS, 768, rows per frame. H_PIXELS*V_PIXELS must be a multiple of 8.
- FB_BASE, 32'h1080_0000, byte address of pixel (0,0). Must be 32-byte aligned.

Ports:
- clk  in  1  cpu clock (cpu_clk_g); all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- filler_color  in  24  fill colour {R,G,B}; sampled on accept.
- filler_valid  in  1  CPU requests a fill.
- filler_ready  out  1  high only in IDLE and not in reset.
- af_addr_din  out  31  burst byte address bits [30:0]; always 32-byte aligned.
- af_wr_en  out  1  push to the address FIFO.
- af_full  in  1  address FIFO full.
- wdf_din  out  128  write data; 4 pixels per word.
- wdf_mask_din  out  16  byte mask; 0 = write. Always 16'h0000.
- wdf_wr_en  out  1  push to the write-data FIFO.
- wdf_full  in  1  write-data FIFO full.
- fill_done  out  1  one-cycle pulse after the last burst of a fill is pushed.

Behaviour:
- Pixel format: 32 bits, {8'h00, colour}. Pixel (x,y) lives at byte FB_BASE + 4*(y*H_PIXELS + x).
- Burst structure: 8 pixels = 32 bytes = one af entry followed by two wdf entries. Both wdf words = {4{8'h00, colour_r}}.
- Burst count: NBURST = H_PIXELS*V_PIXELS/8. Burst k (k from 0 to NBURST-1) goes to FB_BASE + 32*k. Counter width = clog2(NBURST).
- Burst address arithmetic is done in 32 bits; only the low 31 bits drive af_addr_din.
- State IDLE:
  - filler_ready=1.
  - On filler_valid & filler_ready: colour_r <= filler_color, burst counter <= 0, go to CMD.
- State CMD:
  - af_wr_en = wdf_wr_en = ~af_full & ~wdf_full. Both push in the same cycle; af and the first wdf word are never split.
  - On push, go to DATA2. Otherwise hold, with the outputs stable.
- State DATA2:
  - wdf_wr_en = ~wdf_full. af_wr_en = 0.
  - On push: if counter == NBURST-1, go to IDLE and pulse fill_done. Otherwise increment counter and go to CMD.
- Write enables are combinational from state and the full flags. af_addr_din and wdf_din are valid whenever the corresponding enable is high.
- Minimum fill latency with no backpressure: 2*NBURST cycles from the accept edge to the fill_done pulse. For the defaults that is 196608 cycles.
- filler_valid while busy: ignored. filler_ready=0, so there is no accept. The colour is not re-sampled.
- Back-to-back fills: a new accept is possible in the cycle after fill_done, since the block has returned to IDLE.
- Reset values: state=IDLE, counter=0, colour_r=0, fill_done=0, af_wr_en=0, wdf_wr_en=0. filler_ready=0 while rst is high and 1 on the first cycle after it falls.
- Reset mid-fill: abandons the fill immediately and returns to IDLE. There is no fill_done pulse. Partially written pixels keep their new colour.
- Reset mid-burst: may leave an af entry without its second wdf word. The top-level fifo_reset clears the FIFOs in the same window, so this is acceptable.
- Simultaneous full deassertion and rst: rst wins; no enable is asserted.

Test Plan:
- Use H_PIXELS=16, V_PIXELS=2, FB_BASE=32'h1080_0000, giving NBURST=4.
- Basic fill: colour 24'hFF8000, no backpressure -> af pushes at 32'h1080_0000, 0020, 0040, 0060. 8 wdf pushes, each 128'h00FF8000 repeated 4 times, mask 0. fill_done exactly 8 cycles after the accept edge; filler_ready high the next cycle.
- af backpressure: af_full held high for 5 cycles during burst 1 -> no af or wdf push during the stall; addresses and data unchanged; fill_done at 13 cycles.
- wdf_full asserted for 3 cycles in DATA2 of burst 2 -> second word held, then pushed once. Total 8 wdf pushes and 4 af pushes; no duplicates.
- Busy request: assert filler_valid with 24'h00FF00 during the fill -> ignored; all data stays 24'hFF8000; exactly one fill_done.
- Reset mid-fill: rst for 1 cycle after 2 bursts -> enables 0 during rst, no fill_done, filler_ready=1 the next cycle. A new fill of 24'h0000FF then restarts at burst address 32'h1080_0000.
- Back-to-back: filler_valid held high for two fills -> the second accept occurs the cycle after fill_done and produces 4 more bursts with identical addresses.
